// File: rtl/uart_pkg.sv
// Shared definitions for the memory-mapped UART transmitter: FSM states,
// register offsets within the MMIO window and STATUS bit positions.
package uart_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } tx_state_e;

  localparam logic [31:0] TXDATA_OFS = 32'h0000_0000;
  localparam logic [31:0] STATUS_OFS = 32'h0000_0004;

  localparam int STAT_FULL_BIT  = 0;
  localparam int STAT_EMPTY_BIT = 1;
  localparam int STAT_BUSY_BIT  = 2;
  localparam int STAT_OVF_BIT   = 3;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with show-ahead read data; pointers carry an extra MSB so
// full and empty are distinguishable. A push into a full FIFO only lands when
// a pop happens in the same cycle.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_wr_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_rd_data,
  output logic             o_full,
  output logic             o_empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wptr;
  logic [AW:0]      r_rptr;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_empty   = (r_wptr == r_rptr);
  assign o_full    = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign w_do_pop  = i_pop && !o_empty;
  assign w_do_push = i_push && (!o_full || w_do_pop);
  assign o_rd_data = r_mem[r_rptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_do_push) r_wptr <= r_wptr + PTR_ONE;
      if (w_do_pop)  r_rptr <= r_rptr + PTR_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && w_do_push) r_mem[r_wptr[AW-1:0]] <= i_wr_data;
  end

endmodule

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter: TXDATA stores feed a FIFO, a four-state
// FSM serialises bytes LSB first, and STATUS reports overflow/busy/empty/full.
module mmio_uart_tx
  import uart_pkg::*;
#(
  parameter int          CLKS_PER_BIT = 16,
  parameter logic [31:0] BASE_ADDR    = 32'h0000_0100,
  parameter int          FIFO_DEPTH   = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemWrite,
  input  logic [31:0] DataAdr,
  input  logic [31:0] WriteData,
  output logic [31:0] StatusData,
  output logic        txd,
  output logic        busy,
  output tx_state_e   o_dbg_state
);

  localparam logic [15:0] BAUD_LOAD = 16'(CLKS_PER_BIT - 1);

  logic       w_sel_tx;
  logic       w_sel_st;
  logic       w_pop;
  logic       w_full;
  logic       w_empty;
  logic [7:0] w_rd_data;

  tx_state_e   r_state;
  logic [15:0] r_baud;
  logic [2:0]  r_bit_idx;
  logic [7:0]  r_shift;
  logic        r_txd;
  logic        r_overflow;

  assign w_sel_tx = MemWrite && (DataAdr == BASE_ADDR + TXDATA_OFS);
  assign w_sel_st = MemWrite && (DataAdr == BASE_ADDR + STATUS_OFS);

  // Pop only when the line is free: idle, or the final cycle of a stop bit.
  assign w_pop = !w_empty &&
                 ((r_state == ST_IDLE) || ((r_state == ST_STOP) && (r_baud == 16'd0)));

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .i_push    (w_sel_tx),
    .i_wr_data (WriteData[7:0]),
    .i_pop     (w_pop),
    .o_rd_data (w_rd_data),
    .o_full    (w_full),
    .o_empty   (w_empty)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_overflow <= 1'b0;
    end else if (w_sel_tx && w_full && !w_pop) begin
      r_overflow <= 1'b1;
    end else if (w_sel_st && WriteData[STAT_OVF_BIT]) begin
      r_overflow <= 1'b0;
    end
  end

  // txd is registered from the current state, so the line lags the FSM by one
  // cycle uniformly and every bit still lasts CLKS_PER_BIT cycles.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_baud    <= '0;
      r_bit_idx <= '0;
      r_shift   <= '0;
      r_txd     <= 1'b1;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_txd <= 1'b1;
          if (r_baud != 16'd0) r_baud <= r_baud - 16'd1;
          if (w_pop) begin
            r_shift <= w_rd_data;
            r_baud  <= BAUD_LOAD;
            r_state <= ST_START;
          end
        end
        ST_START: begin
          r_txd <= 1'b0;
          if (r_baud == 16'd0) begin
            r_state   <= ST_DATA;
            r_baud    <= BAUD_LOAD;
            r_bit_idx <= '0;
          end else begin
            r_baud <= r_baud - 16'd1;
          end
        end
        ST_DATA: begin
          r_txd <= r_shift[0];
          if (r_baud == 16'd0) begin
            r_baud <= BAUD_LOAD;
            if (r_bit_idx == 3'd7) begin
              r_state <= ST_STOP;
            end else begin
              r_bit_idx <= r_bit_idx + 3'd1;
              r_shift   <= {1'b0, r_shift[7:1]};
            end
          end else begin
            r_baud <= r_baud - 16'd1;
          end
        end
        ST_STOP: begin
          r_txd <= 1'b1;
          if (r_baud == 16'd0) begin
            r_baud <= BAUD_LOAD;
            if (w_pop) begin
              r_shift <= w_rd_data;
              r_state <= ST_START;
            end else begin
              r_state <= ST_IDLE;
            end
          end else begin
            r_baud <= r_baud - 16'd1;
          end
        end
      endcase
    end
  end

  assign txd         = r_txd;
  assign busy        = (r_state != ST_IDLE) || !w_empty;
  assign o_dbg_state = r_state;

  always_comb begin
    StatusData                 = '0;
    StatusData[STAT_FULL_BIT]  = w_full;
    StatusData[STAT_EMPTY_BIT] = w_empty;
    StatusData[STAT_BUSY_BIT]  = busy;
    StatusData[STAT_OVF_BIT]   = r_overflow;
  end

endmodule

// File: doc/mmio_uart_tx.md
MMIO_UART_TX -- requirements
Module: mmio_uart_tx

Interface
REQ-001 Parameter CLKS_PER_BIT, default 16, sets the clk cycles per serial bit; legal range is 2..65535.
REQ-002 Parameter BASE_ADDR, default 32'h0000_0100, sets the word-aligned base of the register window.
REQ-003 Parameter FIFO_DEPTH, default 4, sets the transmit FIFO entries; it SHALL be a power of two, 2..16.
REQ-004 Port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-005 Port reset, input, 1: synchronous, active-high reset.
REQ-006 Port MemWrite, input, 1: processor store strobe.
REQ-007 Port DataAdr, input, 32: processor data address.
REQ-008 Port WriteData, input, 32: processor store data.
REQ-009 Port StatusData, output, 32: combinational read value of the STATUS register.
REQ-010 Port txd, output, 1: serial line, idle high.
REQ-011 Port busy, output, 1: high when the FSM is not IDLE or the FIFO is non-empty.

Function
REQ-012 The block SHALL decode only two registers: TXDATA at BASE_ADDR+0 and STATUS at BASE_ADDR+4; all other addresses SHALL be ignored.
REQ-013 A cycle with MemWrite=1 and DataAdr=TXDATA SHALL push WriteData[7:0] into the FIFO; WriteData[31:8] is ignored.
REQ-014 StatusData SHALL be {28'b0, overflow, busy, fifo_empty, fifo_full} (bits 3..0) regardless of DataAdr.
REQ-015 A push while the FIFO is full and no pop occurs in the same cycle SHALL be dropped and SHALL set the sticky overflow bit.
REQ-016 A write to STATUS with WriteData[3]=1 SHALL clear overflow; if this coincides with a new overflow, set SHALL win.
REQ-017 The FSM states SHALL be IDLE, START, DATA and STOP.
REQ-018 In IDLE with the FIFO non-empty, the FSM SHALL pop one byte and enter START on the next edge.
REQ-019 txd SHALL be 1 in IDLE and STOP, 0 in START, and shift_reg[0] in DATA, sending LSB first.
REQ-020 A baud counter SHALL load CLKS_PER_BIT-1 on every state entry and on every DATA bit advance, and decrement each cycle.
REQ-021 Each state, or each DATA bit, SHALL last exactly CLKS_PER_BIT cycles.
REQ-022 DATA SHALL send 8 bits using a 3-bit index that advances 0..7; at index 7 with the counter at 0, the FSM SHALL enter STOP.
REQ-023 At the end of STOP the FSM SHALL pop and enter START directly if the FIFO is non-empty, with no idle cycle; otherwise it SHALL enter IDLE.
REQ-024 A push and a pop in the same cycle SHALL both succeed, even when the FIFO is full; occupancy is then unchanged and overflow is not set.
REQ-025 Timing: a TXDATA write sampled at edge k with the FSM idle and FIFO empty SHALL drive txd=0 from edge k+2; a frame SHALL take 10*CLKS_PER_BIT cycles.
REQ-026 FIFO read and write pointers SHALL wrap modulo FIFO_DEPTH, with full and empty distinguished by an extra pointer MSB.

Reset
REQ-027 On reset, the FSM SHALL go to IDLE, the FIFO SHALL be emptied, and overflow, the baud counter, the bit index and shift_reg SHALL clear.
REQ-028 On reset, txd SHALL be 1 and busy 0 from the following edge, including when reset arrives mid-frame; the aborted byte is discarded.
REQ-029 A push in the same cycle as reset SHALL be discarded.

Structure
REQ-030 Shared package uart_pkg SHALL hold the FSM state enum, the TXDATA/STATUS offsets and the STATUS bit positions.
REQ-031 The FIFO SHALL be a sub-module named sync_fifo, parameterised by width and depth, with push/pop/full/empty ports.

Verification
REQ-032 CLKS_PER_BIT=4: write 32'h0000_00A5 to 0x100 -> txd=0 from edge k+2 for 4 cycles, then bits 1,0,1,0,0,1,0,1 (4 cycles each), then stop=1; busy falls after 40 cycles.
REQ-033 Write 0x55 and 0x0F back-to-back -> two frames, 80 cycles total, with no idle-high gap between the stop bit and the second start bit.
REQ-034 Write 6 bytes in consecutive cycles with FIFO_DEPTH=4 -> STATUS[0]=1 and STATUS[3]=1, and only 5 bytes are transmitted (4 queued plus 1 popped in flight).
REQ-035 Write 32'h8 to 0x104 -> STATUS[3] reads 0; a write to 0x108 -> no FIFO change.
REQ-036 Assert reset in DATA bit 3 -> txd=1 and StatusData=32'h2 on the next cycle; a subsequent write of 0x3C transmits correctly.
